// File: rtl/gtp_tx_framer_if.sv
// Payload stream into the GTP transmit framer: 16-bit words with valid/last
// from the source and ready back from the framer.
interface gtp_tx_framer_if;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/gtp_tx_framer.sv
// GTP lane transmit framer: K28.5 idles between SOF/payload/checksum/EOF frames.
// Optional macro GTPTX_LENGTH_WORD_EN buffers each packet and inserts a length word after SOF.
module gtp_tx_framer #(
  parameter int MAXLEN   = 1024,
  parameter int IDLE_MIN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  gtp_tx_framer_if.slave        in_if,
  output logic [15:0]           txdata,
  output logic [1:0]            txcharisk,
  output logic                  busy,
  output logic [15:0]           frame_cnt,
  output logic                  trunc_err
);

  localparam int CW = $clog2(MAXLEN + 1);
  localparam int GW = $clog2(IDLE_MIN + 1);

  localparam logic [15:0] K_IDLE = 16'hBCBC;
  localparam logic [15:0] K_SOF  = 16'hFBBC;
  localparam logic [15:0] K_EOF  = 16'hFDBC;

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_SOF  = 4'd1;
  localparam logic [3:0] ST_DATA = 4'd2;
  localparam logic [3:0] ST_CSUM = 4'd3;
  localparam logic [3:0] ST_EOF  = 4'd4;
  localparam logic [3:0] ST_GAP  = 4'd5;
  localparam logic [3:0] ST_DROP = 4'd6;
`ifdef GTPTX_LENGTH_WORD_EN
  localparam logic [3:0] ST_LOAD = 4'd7;
  localparam logic [3:0] ST_LEN  = 4'd8;
  localparam int AW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
`endif

  // EOF/DROP exit plus the final IDLE cycle together put IDLE_MIN idles on the line.
  localparam logic [3:0]    ST_POST  = (IDLE_MIN > 1) ? ST_GAP : ST_IDLE;
  localparam logic [GW-1:0] GAP_LOAD = GW'((IDLE_MIN > 1) ? IDLE_MIN - 2 : 0);

  logic [3:0]    r_state;
  logic [15:0]   r_csum;
  logic [CW-1:0] r_cnt;
  logic [GW-1:0] r_gap;
  logic          r_trunc;
  logic          w_ready;
  logic          w_xfer;

`ifdef GTPTX_LENGTH_WORD_EN
  logic [15:0]   r_mem [MAXLEN];
  logic [CW-1:0] r_rd;

  assign w_ready = (r_state == ST_LOAD);

  always_ff @(posedge clk) begin
    if (r_state == ST_LOAD && w_xfer && r_cnt != CW'(MAXLEN))
      r_mem[r_cnt[AW-1:0]] <= in_if.s_data;
  end
`else
  assign w_ready = (r_state == ST_DATA) || (r_state == ST_DROP);
`endif

  assign in_if.s_ready = w_ready;
  assign w_xfer        = in_if.s_valid && w_ready;
  assign busy          = (r_state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      txdata    <= K_IDLE;
      txcharisk <= 2'b11;
      r_csum    <= '0;
      r_cnt     <= '0;
      r_gap     <= '0;
      r_trunc   <= 1'b0;
      frame_cnt <= '0;
      trunc_err <= 1'b0;
`ifdef GTPTX_LENGTH_WORD_EN
      r_rd      <= '0;
`endif
    end else begin
      txdata    <= K_IDLE;
      txcharisk <= 2'b11;
      trunc_err <= 1'b0;
      case (r_state)
        ST_IDLE: if (enable && in_if.s_valid) begin
`ifdef GTPTX_LENGTH_WORD_EN
          r_cnt   <= '0;
          r_trunc <= 1'b0;
          r_state <= ST_LOAD;
`else
          r_state <= ST_SOF;
`endif
        end
`ifdef GTPTX_LENGTH_WORD_EN
        ST_LOAD: if (w_xfer) begin
          // Words beyond MAXLEN are consumed but not stored.
          if (r_cnt != CW'(MAXLEN)) r_cnt <= r_cnt + 1'b1;
          else                      r_trunc <= 1'b1;
          if (in_if.s_last) r_state <= ST_SOF;
        end
        ST_SOF: begin
          txdata  <= K_SOF;
          r_rd    <= '0;
          r_state <= ST_LEN;
        end
        ST_LEN: begin
          txdata    <= 16'(r_cnt);
          txcharisk <= 2'b00;
          r_csum    <= 16'(r_cnt);
          r_state   <= ST_DATA;
        end
        ST_DATA: begin
          txdata    <= r_mem[r_rd[AW-1:0]];
          txcharisk <= 2'b00;
          r_csum    <= r_csum + r_mem[r_rd[AW-1:0]];
          r_rd      <= r_rd + 1'b1;
          if (r_rd == r_cnt - 1'b1) r_state <= ST_CSUM;
        end
`else
        ST_SOF: begin
          txdata  <= K_SOF;
          r_csum  <= '0;
          r_cnt   <= '0;
          r_state <= ST_DATA;
        end
        // Without a transfer the default IDLE word goes out as an in-frame fill.
        ST_DATA: if (w_xfer) begin
          txdata    <= in_if.s_data;
          txcharisk <= 2'b00;
          r_csum    <= r_csum + in_if.s_data;
          r_cnt     <= r_cnt + 1'b1;
          if (in_if.s_last) begin
            r_state <= ST_CSUM;
          end else if (r_cnt == CW'(MAXLEN - 1)) begin
            r_trunc <= 1'b1;
            r_state <= ST_CSUM;
          end
        end
`endif
        ST_CSUM: begin
          txdata    <= r_csum;
          txcharisk <= 2'b00;
          r_state   <= ST_EOF;
        end
        ST_EOF: begin
          txdata    <= K_EOF;
          frame_cnt <= frame_cnt + 16'd1;
          r_gap     <= GAP_LOAD;
          r_state   <= ST_POST;
          if (r_trunc) begin
            trunc_err <= 1'b1;
            r_trunc   <= 1'b0;
`ifndef GTPTX_LENGTH_WORD_EN
            r_state   <= ST_DROP;
`endif
          end
        end
        ST_DROP: if (w_xfer && in_if.s_last) begin
          r_gap   <= GAP_LOAD;
          r_state <= ST_POST;
        end
        ST_GAP: begin
          if (r_gap == '0) r_state <= ST_IDLE;
          else             r_gap   <= r_gap - 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gtp_tx_framer.sv
// Bench for gtp_tx_framer: directed literal sequences plus randomized packets
// scored against a frame-level model (expected word queue, gap and counter rules).
module tb_gtp_tx_framer;
  localparam int MAXLEN   = 4;
  localparam int IDLE_MIN = 4;
  localparam logic [17:0] W_IDLE = {2'b11, 16'hBCBC};
  localparam logic [17:0] W_SOF  = {2'b11, 16'hFBBC};
  localparam logic [17:0] W_EOF  = {2'b11, 16'hFDBC};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
  logic [15:0] txdata;
  logic [1:0]  txcharisk;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        trunc_err;

  gtp_tx_framer_if bus();

  gtp_tx_framer #(.MAXLEN(MAXLEN), .IDLE_MIN(IDLE_MIN)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_if(bus),
    .txdata(txdata), .txcharisk(txcharisk), .busy(busy),
    .frame_cnt(frame_cnt), .trunc_err(trunc_err)
  );

  always #4 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // kind: 0 SOF, 1 payload, 2 checksum, 3 EOF
  typedef struct {
    logic [17:0] w;
    int          kind;
    logic        trunc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] pkt_w[16];
  int          stall_before[16];
  logic        cur_keep = 1'b1;
  logic        chk_en = 1'b0;
  logic        rand_done;
  logic [18:0] lit[16];

  // Frame-level model state
  int          eofs;
  int          idle_run;
  logic        gap_all_valid, prev_trunc, seen_eof, in_frame;
  logic        p_xfer, p_keep, m_exp_trunc;
  logic [15:0] p_word;
  logic [17:0] m_w;
  exp_t        m_e;

  always @(negedge clk) begin
    if (rst) begin
      eofs = 0; idle_run = 0; gap_all_valid = 1'b1; prev_trunc = 1'b0;
      seen_eof = 1'b0; in_frame = 1'b0; exp_q.delete();
    end else if (chk_en) begin
      m_w = {txcharisk, txdata};
      m_exp_trunc = 1'b0;
      if (p_xfer && p_keep)
        chk("xfer_latency", {14'd0, m_w}, {14'd0, 2'b00, p_word});
      if (m_w == W_IDLE) begin
        if (in_frame)
          chk("fill_position", {31'd0, (exp_q.size() > 0) && (exp_q[0].kind == 1)}, 32'd1);
        else begin
          idle_run++;
          if (!(bus.s_valid && enable)) gap_all_valid = 1'b0;
        end
      end else if (exp_q.size() == 0) begin
        chk("unexpected_word", {14'd0, m_w}, {14'd0, W_IDLE});
      end else begin
        m_e = exp_q.pop_front();
        chk("frame_word", {14'd0, m_w}, {14'd0, m_e.w});
        chk("busy_in_frame", {31'd0, busy}, 32'd1);
        if (m_e.kind == 0) begin
          if (seen_eof) begin
            if (prev_trunc || !gap_all_valid)
              chk("gap_min", {31'd0, idle_run >= IDLE_MIN}, 32'd1);
            else
              chk("gap_exact", idle_run, IDLE_MIN);
          end
          in_frame = 1'b1;
        end
        if (m_e.kind == 3) begin
          eofs++; in_frame = 1'b0; idle_run = 0; gap_all_valid = 1'b1;
          prev_trunc = m_e.trunc; seen_eof = 1'b1; m_exp_trunc = m_e.trunc;
        end
      end
      chk("trunc_err", {31'd0, trunc_err}, {31'd0, m_exp_trunc});
      chk("frame_cnt", {16'd0, frame_cnt}, eofs & 32'hFFFF);
    end
    p_xfer = bus.s_valid && bus.s_ready && !rst;
    p_keep = cur_keep;
    p_word = bus.s_data;
  end

  task automatic send_pkt(input int len);
    logic [15:0] cs;
    int kept;
    logic ok;
    exp_t e;
    cs = 16'd0;
    kept = (len > MAXLEN) ? MAXLEN : len;
    e = '{W_SOF, 0, 1'b0}; exp_q.push_back(e);
    for (int i = 0; i < kept; i++) begin
      cs = cs + pkt_w[i];
      e = '{{2'b00, pkt_w[i]}, 1, 1'b0}; exp_q.push_back(e);
    end
    e = '{{2'b00, cs}, 2, 1'b0}; exp_q.push_back(e);
    e = '{W_EOF, 3, len > MAXLEN}; exp_q.push_back(e);
    for (int i = 0; i < len; i++) begin
      for (int k = 0; k < stall_before[i]; k++) begin
        bus.s_valid = 1'b0; @(posedge clk); #1;
      end
      bus.s_valid = 1'b1; bus.s_data = pkt_w[i];
      bus.s_last = (i == len - 1); cur_keep = (i < MAXLEN);
      ok = 1'b0;
      for (int t = 0; t < 200 && !ok; t++) begin
        @(negedge clk); ok = bus.s_ready;
        @(posedge clk); #1;
      end
      if (!ok) begin
        chk("handshake_timeout", 32'd0, 32'd1);
        break;
      end
    end
    bus.s_valid = 1'b0; bus.s_last = 1'b0; cur_keep = 1'b1;
  endtask

  task automatic expect_seq(input string name, input int n);
    int t;
    logic found;
    t = 0; found = 1'b0;
    while (!found && t < 300) begin
      @(negedge clk);
      found = ({txcharisk, txdata} == W_SOF);
      t++;
    end
    chk({name, "_sof_seen"}, {31'd0, found}, 32'd1);
    if (found)
      for (int i = 0; i < n; i++) begin
        if (i > 0) @(negedge clk);
        chk(name, {13'd0, trunc_err, txcharisk, txdata}, {13'd0, lit[i]});
      end
  endtask

  task automatic set_lit(input int i, input logic t, input logic [17:0] w);
    lit[i] = {t, w};
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_data = 16'd0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin @(negedge clk); t++; end
    chk("drain", exp_q.size(), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) begin stall_before[i] = 0; pkt_w[i] = 16'd0; end
    do_reset();
    chk_en = 1'b1;

    // Idle line after reset
    repeat (8) begin
      @(negedge clk);
      chk("reset_idle", {14'd0, txcharisk, txdata}, {14'd0, W_IDLE});
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_ready", {31'd0, bus.s_ready}, 32'd0);
      chk("reset_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    end

    // Three-word packet, valid held
    pkt_w[0] = 16'h0001; pkt_w[1] = 16'h0002; pkt_w[2] = 16'hFFFF;
    set_lit(0, 0, W_SOF); set_lit(1, 0, {2'b00, 16'h0001}); set_lit(2, 0, {2'b00, 16'h0002});
    set_lit(3, 0, {2'b00, 16'hFFFF}); set_lit(4, 0, {2'b00, 16'h0002}); set_lit(5, 0, W_EOF);
    for (int i = 6; i < 10; i++) set_lit(i, 0, W_IDLE);
    fork
      expect_seq("basic_seq", 10);
      send_pkt(3);
    join
    chk("basic_frame_cnt", {16'd0, frame_cnt}, 32'd1);

    // Same packet with a two-cycle underrun after the first word
    stall_before[1] = 2;
    set_lit(2, 0, W_IDLE); set_lit(3, 0, W_IDLE); set_lit(4, 0, {2'b00, 16'h0002});
    set_lit(5, 0, {2'b00, 16'hFFFF}); set_lit(6, 0, {2'b00, 16'h0002}); set_lit(7, 0, W_EOF);
    fork
      expect_seq("underrun_seq", 8);
      send_pkt(3);
    join
    stall_before[1] = 0;

    // Six words into a MAXLEN=4 framer
    for (int i = 0; i < 6; i++) pkt_w[i] = 16'(i + 1);
    for (int i = 1; i <= 4; i++) set_lit(i, 0, {2'b00, 16'(i)});
    set_lit(5, 0, {2'b00, 16'h000A}); set_lit(6, 1, W_EOF);
    set_lit(7, 0, W_IDLE); set_lit(8, 0, W_IDLE);
    fork
      expect_seq("trunc_seq", 9);
      send_pkt(6);
    join
    drain();

    // Randomized packets, stalls and enable toggling
    rand_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 40; p++) begin
          int len;
          len = $urandom_range(1, 7);
          for (int i = 0; i < len; i++) begin
            pkt_w[i] = 16'($urandom);
            stall_before[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
          end
          send_pkt(len);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          enable = ($urandom_range(0, 7) != 0);
        end
        enable = 1'b1;
      end
    join
    for (int i = 0; i < 16; i++) stall_before[i] = 0;
    drain();

    // Back-to-back single-word packets from reset
    do_reset();
    set_lit(0, 0, W_SOF); set_lit(1, 0, {2'b00, 16'hAAAA}); set_lit(2, 0, {2'b00, 16'hAAAA});
    set_lit(3, 0, W_EOF);
    for (int i = 4; i < 8; i++) set_lit(i, 0, W_IDLE);
    set_lit(8, 0, W_SOF); set_lit(9, 0, {2'b00, 16'h5555}); set_lit(10, 0, {2'b00, 16'h5555});
    set_lit(11, 0, W_EOF);
    fork
      expect_seq("b2b_seq", 12);
      begin
        pkt_w[0] = 16'hAAAA; send_pkt(1);
        pkt_w[0] = 16'h5555; send_pkt(1);
      end
    join
    chk("b2b_frame_cnt", {16'd0, frame_cnt}, 32'd2);
    drain();

    // Reset asserted mid-frame while in DATA
    chk_en = 1'b0;
    bus.s_valid = 1'b1; bus.s_data = 16'h1234; bus.s_last = 1'b0;
    begin
      int t;
      t = 0;
      while ({txcharisk, txdata} != W_SOF && t < 100) begin @(negedge clk); t++; end
      chk("midrst_sof_seen", {31'd0, {txcharisk, txdata} == W_SOF}, 32'd1);
    end
    @(posedge clk); #2;
    chk("midrst_pre_data", {14'd0, txcharisk, txdata}, {14'd0, 2'b00, 16'h1234});
    chk("midrst_pre_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1; #1;
    chk("midrst_idle", {14'd0, txcharisk, txdata}, {14'd0, W_IDLE});
    chk("midrst_ready", {31'd0, bus.s_ready}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("midrst_trunc", {31'd0, trunc_err}, 32'd0);
    bus.s_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("postrst_idle", {14'd0, txcharisk, txdata}, {14'd0, W_IDLE});
      chk("postrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
